// File: rtl/uart_frame_codec_if.sv
// Byte-level link between uart_frame_codec (master modport) and the board UART PHY (slave modport).
interface uart_frame_codec_if;
    // TX: phy_tx_req is a 1-cycle request and phy_tx_data holds until the PHY answers with a 1-cycle
    // phy_tx_done; the next request never precedes that done. RX: phy_rx_vld is a 1-cycle strobe
    // qualifying phy_rx_data, with no back-pressure.
    logic [7:0] phy_tx_data;
    logic       phy_tx_req;
    logic       phy_tx_done;
    logic [7:0] phy_rx_data;
    logic       phy_rx_vld;

    modport master (
        output phy_tx_data,
        output phy_tx_req,
        input  phy_tx_done,
        input  phy_rx_data,
        input  phy_rx_vld
    );

    modport slave (
        input  phy_tx_data,
        input  phy_tx_req,
        output phy_tx_done,
        output phy_rx_data,
        output phy_rx_vld
    );
endinterface

// File: rtl/uart_frame_codec.sv
// Delimiter framer/deframer between a flat payload vector and a byte UART PHY.
// Optional feature: define UART_FRAME_CHKSUM_EN to add a mod-256 checksum byte before the trailer.
module uart_frame_codec #(
    parameter int         MAX_LEN        = 64,
    parameter logic [7:0] DELIM          = 8'h26,
    parameter int         DELIM_CNT      = 2,
    parameter int         RX_TIMEOUT_CLK = 100000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [MAX_LEN*8-1:0] tx_string,
    input  logic [7:0]           tx_length,
    input  logic                 tx_req,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_err,
    output logic [MAX_LEN*8-1:0] rx_string,
    output logic [7:0]           rx_length,
    output logic                 rx_busy,
    output logic                 rx_done,
    output logic [1:0]           rx_err,
    uart_frame_codec_if.master   phy,
    output logic [2:0]           dbg_tx_state_o,
    output logic                 dbg_rx_state_o
);
`ifdef UART_FRAME_CHKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif
    localparam logic [7:0] RX_OVF_PTR = 8'(MAX_LEN + DELIM_CNT + CHK_BYTES);
    localparam logic [7:0] LAST_DELIM = 8'(DELIM_CNT - 1);
    localparam int         TW         = $clog2(RX_TIMEOUT_CLK + 1);

    typedef enum logic [2:0] {
        T_IDLE,
        T_HEAD,
        T_BODY,
`ifdef UART_FRAME_CHKSUM_EN
        T_CHK,
`endif
        T_TAIL,
        T_DONE
    } tx_state_e;

    typedef enum logic {R_HUNT, R_BODY} rx_state_e;

    tx_state_e            tx_state_q;
    logic [MAX_LEN*8-1:0] tx_buf_q;
    logic [7:0]           tx_len_q, tx_cnt_q, phy_tx_data_q;
    logic                 phy_tx_req_q, tx_busy_q, tx_done_q, tx_err_q;
    rx_state_e            rx_state_q;
    logic [MAX_LEN*8-1:0] rx_string_q;
    logic [7:0]           rx_length_q, rx_wr_ptr_q, rx_run_q;
    logic [TW-1:0]        rx_timer_q;
    logic                 rx_busy_q, rx_done_q;
    logic [1:0]           rx_err_q;
    tx_state_e            tx_after_st;
    logic [7:0]           tx_after_byte;
    logic                 tx_byte_done;

`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0] tx_sum_q, rx_sum_q, rx_last_q, rx_pay_sum;

    // The checksum byte must never look like a delimiter on the wire.
    function automatic logic [7:0] chk_map(input logic [7:0] sum);
        return (sum == DELIM) ? 8'h00 : sum;
    endfunction

    assign tx_after_st   = T_CHK;
    assign tx_after_byte = chk_map(tx_sum_q);
    // rx_sum_q holds every body byte so far: payload, chk and all but the final trailer delimiter.
    assign rx_pay_sum    = rx_sum_q - 8'((DELIM_CNT - 1) * int'(DELIM)) - rx_last_q;
`else
    assign tx_after_st   = T_TAIL;
    assign tx_after_byte = DELIM;
`endif

    assign tx_byte_done = phy.phy_tx_done && !phy_tx_req_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_state_q    <= T_IDLE;
            tx_buf_q      <= '0;
            tx_len_q      <= '0;
            tx_cnt_q      <= '0;
            phy_tx_data_q <= '0;
            phy_tx_req_q  <= 1'b0;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_err_q      <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
            tx_sum_q      <= '0;
`endif
        end else begin
            phy_tx_req_q <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            case (tx_state_q)
                T_IDLE: if (tx_req) begin
                    if (tx_length > 8'(MAX_LEN)) begin
                        tx_err_q <= 1'b1;
                    end else begin
                        tx_buf_q      <= tx_string;
                        tx_len_q      <= tx_length;
                        tx_cnt_q      <= '0;
                        tx_busy_q     <= 1'b1;
                        phy_tx_req_q  <= 1'b1;
                        phy_tx_data_q <= DELIM;
                        tx_state_q    <= T_HEAD;
`ifdef UART_FRAME_CHKSUM_EN
                        tx_sum_q      <= '0;
`endif
                    end
                end
                T_HEAD: if (tx_byte_done) begin
                    phy_tx_req_q <= 1'b1;
                    if (tx_cnt_q != LAST_DELIM) begin
                        tx_cnt_q      <= tx_cnt_q + 8'd1;
                        phy_tx_data_q <= DELIM;
                    end else if (tx_len_q != 8'd0) begin
                        tx_cnt_q      <= '0;
                        phy_tx_data_q <= tx_buf_q[7:0];
                        tx_buf_q      <= tx_buf_q >> 8;
                        tx_state_q    <= T_BODY;
`ifdef UART_FRAME_CHKSUM_EN
                        tx_sum_q      <= tx_sum_q + tx_buf_q[7:0];
`endif
                    end else begin
                        tx_cnt_q      <= '0;
                        phy_tx_data_q <= tx_after_byte;
                        tx_state_q    <= tx_after_st;
                    end
                end
                // The payload is consumed from the low byte of a shift register.
                T_BODY: if (tx_byte_done) begin
                    phy_tx_req_q <= 1'b1;
                    if (tx_cnt_q != tx_len_q - 8'd1) begin
                        tx_cnt_q      <= tx_cnt_q + 8'd1;
                        phy_tx_data_q <= tx_buf_q[7:0];
                        tx_buf_q      <= tx_buf_q >> 8;
`ifdef UART_FRAME_CHKSUM_EN
                        tx_sum_q      <= tx_sum_q + tx_buf_q[7:0];
`endif
                    end else begin
                        tx_cnt_q      <= '0;
                        phy_tx_data_q <= tx_after_byte;
                        tx_state_q    <= tx_after_st;
                    end
                end
`ifdef UART_FRAME_CHKSUM_EN
                T_CHK: if (tx_byte_done) begin
                    phy_tx_req_q  <= 1'b1;
                    phy_tx_data_q <= DELIM;
                    tx_cnt_q      <= '0;
                    tx_state_q    <= T_TAIL;
                end
`endif
                T_TAIL: if (tx_byte_done) begin
                    if (tx_cnt_q != LAST_DELIM) begin
                        tx_cnt_q      <= tx_cnt_q + 8'd1;
                        phy_tx_req_q  <= 1'b1;
                        phy_tx_data_q <= DELIM;
                    end else begin
                        tx_done_q  <= 1'b1;
                        tx_state_q <= T_DONE;
                    end
                end
                T_DONE: begin
                    tx_busy_q  <= 1'b0;
                    tx_state_q <= T_IDLE;
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_state_q  <= R_HUNT;
            rx_string_q <= '0;
            rx_length_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_run_q    <= '0;
            rx_timer_q  <= '0;
            rx_busy_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_err_q    <= 2'b00;
`ifdef UART_FRAME_CHKSUM_EN
            rx_sum_q    <= '0;
            rx_last_q   <= '0;
`endif
        end else begin
            rx_done_q <= 1'b0;
            rx_err_q  <= 2'b00;
            case (rx_state_q)
                R_HUNT: if (phy.phy_rx_vld) begin
                    if (phy.phy_rx_data != DELIM) begin
                        rx_run_q <= '0;
                    end else if (rx_run_q != LAST_DELIM) begin
                        rx_run_q <= rx_run_q + 8'd1;
                    end else begin
                        rx_run_q    <= '0;
                        rx_wr_ptr_q <= '0;
                        rx_timer_q  <= '0;
                        rx_busy_q   <= 1'b1;
                        rx_state_q  <= R_BODY;
`ifdef UART_FRAME_CHKSUM_EN
                        rx_sum_q    <= '0;
                        rx_last_q   <= '0;
`endif
                    end
                end
                R_BODY: if (phy.phy_rx_vld) begin
                    rx_timer_q <= '0;
                    if (rx_wr_ptr_q == RX_OVF_PTR) begin
                        rx_err_q   <= 2'b01;
                        rx_busy_q  <= 1'b0;
                        rx_run_q   <= '0;
                        rx_state_q <= R_HUNT;
                    end else begin
                        // Trailer delimiters land in rx_string too; they sit past rx_length.
                        for (int k = 0; k < MAX_LEN; k++) begin
                            if (rx_wr_ptr_q == 8'(k)) rx_string_q[8*k +: 8] <= phy.phy_rx_data;
                        end
                        rx_wr_ptr_q <= rx_wr_ptr_q + 8'd1;
`ifdef UART_FRAME_CHKSUM_EN
                        rx_sum_q    <= rx_sum_q + phy.phy_rx_data;
`endif
                        if (phy.phy_rx_data != DELIM) begin
                            rx_run_q  <= '0;
`ifdef UART_FRAME_CHKSUM_EN
                            rx_last_q <= phy.phy_rx_data;
`endif
                        end else if (rx_run_q != LAST_DELIM) begin
                            rx_run_q <= rx_run_q + 8'd1;
                        end else begin
                            rx_run_q   <= '0;
                            rx_busy_q  <= 1'b0;
                            rx_state_q <= R_HUNT;
`ifdef UART_FRAME_CHKSUM_EN
                            if (rx_wr_ptr_q == LAST_DELIM || chk_map(rx_pay_sum) != rx_last_q) begin
                                rx_err_q <= 2'b11;
                            end else begin
                                rx_length_q <= rx_wr_ptr_q - 8'(DELIM_CNT);
                                rx_done_q   <= 1'b1;
                            end
`else
                            rx_length_q <= rx_wr_ptr_q + 8'd1 - 8'(DELIM_CNT);
                            rx_done_q   <= 1'b1;
`endif
                        end
                    end
                end else if (rx_timer_q == TW'(RX_TIMEOUT_CLK - 1)) begin
                    rx_err_q   <= 2'b10;
                    rx_busy_q  <= 1'b0;
                    rx_run_q   <= '0;
                    rx_state_q <= R_HUNT;
                end else begin
                    rx_timer_q <= rx_timer_q + 1'b1;
                end
                default: rx_state_q <= R_HUNT;
            endcase
        end
    end

    assign phy.phy_tx_data = phy_tx_data_q;
    assign phy.phy_tx_req  = phy_tx_req_q;
    assign tx_busy         = tx_busy_q;
    assign tx_done         = tx_done_q;
    assign tx_err          = tx_err_q;
    assign rx_string       = rx_string_q;
    assign rx_length       = rx_length_q;
    assign rx_busy         = rx_busy_q;
    assign rx_done         = rx_done_q;
    assign rx_err          = rx_err_q;
    assign dbg_tx_state_o  = tx_state_q;
    assign dbg_rx_state_o  = rx_state_q;
endmodule

// File: tb/tb_uart_frame_codec.sv
// Scoreboard bench for uart_frame_codec: TX bytes and RX results are queued as expected and popped on output.
module tb_uart_frame_codec;
    localparam int         MAX_LEN = 64;
    localparam logic [7:0] DELIM   = 8'h26;
    localparam int         DCNT    = 2;
    localparam int         RX_TO   = 200;
    localparam int         PHY_DLY = 10;
`ifdef UART_FRAME_CHKSUM_EN
    localparam int         CHK_ON  = 1;
`else
    localparam int         CHK_ON  = 0;
`endif

    logic                 clk = 1'b0;
    logic                 sys_rst;
    logic [MAX_LEN*8-1:0] tx_string;
    logic [7:0]           tx_length;
    logic                 tx_req;
    logic                 tx_busy, tx_done, tx_err;
    logic [MAX_LEN*8-1:0] rx_string;
    logic [7:0]           rx_length;
    logic                 rx_busy, rx_done;
    logic [1:0]           rx_err;
    logic [2:0]           dbg_tx_state;
    logic                 dbg_rx_state;

    uart_frame_codec_if phy_if ();

    uart_frame_codec #(
        .MAX_LEN(MAX_LEN), .DELIM(DELIM), .DELIM_CNT(DCNT), .RX_TIMEOUT_CLK(RX_TO)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst),
        .tx_string(tx_string), .tx_length(tx_length), .tx_req(tx_req),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
        .rx_string(rx_string), .rx_length(rx_length), .rx_busy(rx_busy),
        .rx_done(rx_done), .rx_err(rx_err),
        .phy(phy_if),
        .dbg_tx_state_o(dbg_tx_state), .dbg_rx_state_o(dbg_rx_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int tx_done_seen = 0;
    int tx_done_exp = 0;
    logic [7:0]  tx_exp_q[$];
    logic [73:0] rx_exp_q[$];   // {code, length, first 8 payload bytes}; code 0 = rx_done

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] chk_map(input logic [7:0] c);
        return (c == DELIM) ? 8'h00 : c;
    endfunction

    function automatic logic [7:0] rand_nd();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == DELIM);
        return b;
    endfunction

    function automatic logic [511:0] rand_payload(input int len);
        logic [511:0] pl = '0;
        for (int k = 0; k < len; k++) pl[8*k +: 8] = rand_nd();
        return pl;
    endfunction

    // PHY TX model: answers each request with a 1-cycle done PHY_DLY clocks later.
    initial begin
        phy_if.phy_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            phy_if.phy_tx_done = 1'b0;
            if (phy_if.phy_tx_req) begin
                repeat (PHY_DLY - 1) @(negedge clk);
                phy_if.phy_tx_done = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (phy_if.phy_tx_req) begin
                check("tx_busy_req", tx_busy, 1);
                if (tx_exp_q.size() == 0) check("tx_extra", tx_exp_q.size(), 1);
                else check("tx_byte", phy_if.phy_tx_data, tx_exp_q.pop_front());
            end
            if (tx_done) begin
                tx_done_seen++;
                check("tx_busy_done", tx_busy, 1);
            end
        end
    end

    initial begin
        logic [73:0] e;
        logic [1:0]  code;
        forever begin
            @(negedge clk);
            if (rx_done || rx_err != 2'b00) begin
                code = rx_done ? 2'b00 : rx_err;
                if (rx_exp_q.size() == 0) begin
                    check("rx_extra", rx_exp_q.size(), 1);
                end else begin
                    e = rx_exp_q.pop_front();
                    check("rx_code", code, e[73:72]);
                    if (e[73:72] == 2'b00) begin
                        check("rx_len", rx_length, e[71:64]);
                        for (int k = 0; k < 8 && k < int'(e[71:64]); k++)
                            check("rx_byte", rx_string[8*k +: 8], e[8*k +: 8]);
                    end
                end
            end
        end
    end

    task automatic tx_drive(input logic [511:0] pl, input int len);
        int n = 0;
        @(negedge clk);
        tx_string = pl;
        tx_length = 8'(len);
        tx_req    = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        check("tx_busy_start", tx_busy, 1);
        while (!tx_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("tx_done_wait", tx_done, 1);
        @(negedge clk);
        check("tx_busy_end", tx_busy, 0);
    endtask

    task automatic tx_send(input logic [511:0] pl, input int len);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < DCNT; i++) tx_exp_q.push_back(DELIM);
        for (int k = 0; k < len; k++) begin
            tx_exp_q.push_back(pl[8*k +: 8]);
            s = s + pl[8*k +: 8];
        end
        if (CHK_ON != 0) tx_exp_q.push_back(chk_map(s));
        for (int i = 0; i < DCNT; i++) tx_exp_q.push_back(DELIM);
        tx_done_exp++;
        tx_drive(pl, len);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        phy_if.phy_rx_data = b;
        phy_if.phy_rx_vld  = 1'b1;
        @(negedge clk);
        phy_if.phy_rx_vld = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [511:0] pl, input int len, input bit bad_chk);
        logic [7:0] s = 8'h00;
        logic [7:0] c;
        rx_exp_q.push_back({(CHK_ON != 0 && bad_chk) ? 2'b11 : 2'b00, 8'(len), pl[63:0]});
        for (int i = 0; i < DCNT; i++) rx_byte(DELIM);
        for (int k = 0; k < len; k++) begin
            rx_byte(pl[8*k +: 8]);
            s = s + pl[8*k +: 8];
        end
        if (CHK_ON != 0) begin
            c = chk_map(s);
            if (bad_chk) begin
                c = c + 8'd1;
                if (c == DELIM) c = c + 8'd1;
            end
            rx_byte(c);
        end
        for (int i = 0; i < DCNT; i++) rx_byte(DELIM);
    endtask

    task automatic rx_drain(input int budget);
        int n = 0;
        while (rx_exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rx_drain", rx_exp_q.size(), 0);
    endtask

    initial begin
        logic [511:0] pl;
        int           n;
        sys_rst = 1'b1;
        tx_string = '0;
        tx_length = '0;
        tx_req = 1'b0;
        phy_if.phy_rx_data = '0;
        phy_if.phy_rx_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_err", tx_err, 0);
        check("rst_phy_req", phy_if.phy_tx_req, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_rx_done", rx_done, 0);
        check("rst_rx_err", rx_err, 0);
        check("rst_rx_len", rx_length, 0);
        sys_rst = 1'b0;
        @(negedge clk);

        // "ABC" framed
        pl = '0;
        pl[23:0] = 24'h434241;
        tx_send(pl, 3);

        // Oversized request is dropped with an error pulse
        @(negedge clk);
        tx_length = 8'(MAX_LEN + 1);
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        check("tx_err", tx_err, 1);
        check("tx_err_busy", tx_busy, 0);
        @(negedge clk);
        check("tx_err_pulse", tx_err, 0);
        repeat (20) @(negedge clk);

        // "x&&hi&&": leading junk ignored
        pl = '0;
        pl[15:0] = 16'h6968;
        rx_exp_q.push_back({2'b00, 8'd2, pl[63:0]});
        rx_byte(8'h78);
        rx_byte(DELIM);
        rx_byte(DELIM);
        check("rx_busy_hdr", rx_busy, 1);
        rx_byte(8'h68);
        rx_byte(8'h69);
        if (CHK_ON != 0) rx_byte(chk_map(8'h68 + 8'h69));
        rx_byte(DELIM);
        rx_byte(DELIM);
        rx_drain(20);
        check("rx_busy_end", rx_busy, 0);

        // "&&&&": empty frame
        rx_exp_q.push_back({(CHK_ON != 0) ? 2'b11 : 2'b00, 8'd0, 64'd0});
        for (int i = 0; i < 2 * DCNT; i++) rx_byte(DELIM);
        rx_drain(20);

        // Overflow, then a short frame decodes cleanly
        rx_exp_q.push_back({2'b01, 8'd0, 64'd0});
        for (int i = 0; i < DCNT; i++) rx_byte(DELIM);
        for (int i = 0; i < MAX_LEN + DCNT + 1 + CHK_ON; i++) rx_byte(rand_nd());
        rx_drain(20);
        pl = '0;
        pl[7:0] = 8'h5A;
        rx_frame(pl, 1, 1'b0);
        rx_drain(20);

        // Inter-byte timeout
        rx_exp_q.push_back({2'b10, 8'd0, 64'd0});
        rx_byte(DELIM);
        rx_byte(DELIM);
        rx_byte(8'h61);
        rx_byte(8'h62);
        rx_drain(RX_TO + 50);
        check("rx_busy_to", rx_busy, 0);

`ifdef UART_FRAME_CHKSUM_EN
        pl = '0;
        pl[15:0] = 16'h4241;
        tx_exp_q.push_back(DELIM);
        tx_exp_q.push_back(DELIM);
        tx_exp_q.push_back(8'h41);
        tx_exp_q.push_back(8'h42);
        tx_exp_q.push_back(8'h83);
        tx_exp_q.push_back(DELIM);
        tx_exp_q.push_back(DELIM);
        tx_done_exp++;
        tx_drive(pl, 2);
        rx_frame(pl, 2, 1'b1);
        rx_drain(20);
`endif

        // Concurrent random traffic on both directions
        for (int it = 0; it < 3; it++) begin
            fork
                tx_send(rand_payload($urandom_range(1, 8)), 0 + 0);
                begin end
            join
        end
        for (int it = 0; it < 3; it++) begin
            int tl, rl;
            logic [511:0] tp, rp;
            tl = $urandom_range(1, 8);
            rl = $urandom_range(0, 8);
            tp = rand_payload(tl);
            rp = rand_payload(rl);
            fork
                tx_send(tp, tl);
                begin
                    rx_frame(rp, rl, 1'b0);
                    rx_drain(20);
                end
            join
        end

        // Maximum length both ways
        tx_send(rand_payload(MAX_LEN), MAX_LEN);
        rx_frame(rand_payload(MAX_LEN), MAX_LEN, 1'b0);
        rx_drain(20);

        // Reset in the middle of a transmission
        pl = '0;
        pl[23:0] = 24'h434241;
        for (int i = 0; i < DCNT; i++) tx_exp_q.push_back(DELIM);
        for (int k = 0; k < 3; k++) tx_exp_q.push_back(pl[8*k +: 8]);
        @(negedge clk);
        tx_string = pl;
        tx_length = 8'd3;
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        n = 0;
        while (tx_exp_q.size() > 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_progress", tx_exp_q.size(), 2);
        sys_rst = 1'b1;
        @(negedge clk);
        check("rst_mid_phy_req", phy_if.phy_tx_req, 0);
        check("rst_mid_tx_busy", tx_busy, 0);
        check("rst_mid_rx_len", rx_length, 0);
        sys_rst = 1'b0;
        tx_exp_q.delete();
        repeat (30) @(negedge clk);

        check("tx_done_cnt", tx_done_seen, tx_done_exp);
        check("tx_q_left", tx_exp_q.size(), 0);
        check("rx_q_left", rx_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want completion before 50000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
